// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants, FSM state type and token helper for the TMDS receive path
// Contents:
//   WORD_W            width of one TMDS character (10)
//   CTRL_TOKEN_00..11 the four control-period tokens, indexed by their {C1,C0} value
//   state_e           word-alignment FSM states
//   is_token()        1 when a 10-bit word equals any control token
package tmds_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    function automatic logic is_token(input logic [WORD_W-1:0] w);
        return (w == CTRL_TOKEN_00) || (w == CTRL_TOKEN_01) ||
               (w == CTRL_TOKEN_10) || (w == CTRL_TOKEN_11);
    endfunction

endpackage

// File: rtl/tmds_decode.sv
// rtl/tmds_decode.sv - combinational TMDS 10b->8b data decode plus control-token decode
// Ports:
//   word_i  in  10  aligned TMDS character, bit 0 = first bit on the wire
//   data_o  out 8   decoded pixel byte (0 for control tokens)
//   ctrl_o  out 2   {C1,C0} for control tokens, 0 for data characters
//   de_o    out 1   1 = data character, 0 = control token
module tmds_decode
    import tmds_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [7:0]        data_o,
    output logic [1:0]        ctrl_o,
    output logic              de_o
);

    logic [7:0] q;

    always_comb begin
        // bit 9 flags that the encoder inverted the payload
        q      = word_i[9] ? ~word_i[7:0] : word_i[7:0];
        data_o = 8'h00;
        ctrl_o = 2'b00;
        de_o   = 1'b1;
        data_o[0] = q[0];
        // bit 8 selects XOR (1) or XNOR (0) chaining in the encoder
        for (int i = 1; i < 8; i++) begin
            data_o[i] = word_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        case (word_i)
            CTRL_TOKEN_00: begin de_o = 1'b0; ctrl_o = 2'b00; data_o = 8'h00; end
            CTRL_TOKEN_01: begin de_o = 1'b0; ctrl_o = 2'b01; data_o = 8'h00; end
            CTRL_TOKEN_10: begin de_o = 1'b0; ctrl_o = 2'b10; data_o = 8'h00; end
            CTRL_TOKEN_11: begin de_o = 1'b0; ctrl_o = 2'b11; data_o = 8'h00; end
            default: ;
        endcase
    end

endmodule

// File: rtl/tmds_deserializer.sv
// rtl/tmds_deserializer.sv - TMDS lane deserializer with token-based word alignment and lock tracking
// Ports:
//   clk_TMDS    in  1   bit clock (10x pixel clock)
//   rst         in  1   asynchronous active-high reset
//   serial_in   in  1   serial bit, LSB of each word first
//   realign     in  1   pulse: drop lock and restart the boundary search
//   word        out 10  aligned word, word[0] = first bit received
//   word_valid  out 1   one-cycle strobe per emitted word (LOCKED only)
//   locked      out 1   high while the FSM is in LOCKED
//   data        out 8   decoded pixel byte      (TMDS_DECODE_EN, else 0)
//   ctrl        out 2   decoded {C1,C0}         (TMDS_DECODE_EN, else 0)
//   de          out 1   1 = data, 0 = control   (TMDS_DECODE_EN, else 0)
// Build option: define TMDS_DECODE_EN to build and register the 10b->8b decoder.
module tmds_deserializer
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 4,
    parameter int TIMEOUT_WORDS = 4096
) (
    input  logic              clk_TMDS,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              realign,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              locked,
    output logic [7:0]        data,
    output logic [1:0]        ctrl,
    output logic              de
);

    localparam int HITS_W = $clog2(LOCK_TOKENS + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_WORDS + 1);
    localparam logic [HITS_W-1:0] HITS_LOCK = HITS_W'(LOCK_TOKENS);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_WORDS);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [3:0]          ph_q, ph_d;
    logic [HITS_W-1:0]   hits_q, hits_d, hits_inc;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                valid_q, valid_d;
    logic                tok, boundary, emit;

    assign tok      = is_token(sr_q);
    assign boundary = (ph_q == 4'd9);
    assign hits_inc = hits_q + 1'b1;
    // saturate so a long token-free run can never wrap back below the limit
    assign tcnt_inc = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + 1'b1;

    always_ff @(posedge clk_TMDS or posedge rst) begin
        if (rst) state_q <= SEARCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (realign) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH:  if (tok) state_d = CONFIRM;
                CONFIRM: if (boundary) begin
                             if (!tok)                  state_d = SEARCH;
                             else if (hits_inc == HITS_LOCK) state_d = LOCKED;
                         end
                LOCKED:  if (boundary && !tok && (tcnt_inc == TCNT_MAX)) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        sr_d   = {serial_in, sr_q[WORD_W-1:1]};
        ph_d   = boundary ? 4'd0 : ph_q + 4'd1;
        hits_d = hits_q;
        tcnt_d = '0;
        // the lock-entry boundary is not emitted, nor is one that leaves LOCKED
        emit   = (state_q == LOCKED) && boundary && (state_d == LOCKED);
        if (!realign) begin
            case (state_q)
                SEARCH: begin
                    hits_d = tok ? HITS_W'(1) : '0;
                    if (tok) ph_d = 4'd0;   // the hit cycle itself is a boundary
                end
                CONFIRM: if (boundary) hits_d = tok ? hits_inc : '0;
                LOCKED: begin
                    hits_d = '0;
                    tcnt_d = tcnt_q;
                    if (boundary) tcnt_d = tok ? '0 : tcnt_inc;
                end
                default: hits_d = '0;
            endcase
        end else begin
            hits_d = '0;
        end
        if (state_d != LOCKED) tcnt_d = '0;
        valid_d = emit;
        word_d  = emit ? sr_q : word_q;
    end

    always_ff @(posedge clk_TMDS or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            ph_q    <= '0;
            hits_q  <= '0;
            tcnt_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            ph_q    <= ph_d;
            hits_q  <= hits_d;
            tcnt_q  <= tcnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign locked     = (state_q == LOCKED);

`ifdef TMDS_DECODE_EN
    logic [7:0] dec_data, data_q;
    logic [1:0] dec_ctrl, ctrl_q;
    logic       dec_de,   de_q;

    tmds_decode u_decode (
        .word_i (sr_q),
        .data_o (dec_data),
        .ctrl_o (dec_ctrl),
        .de_o   (dec_de)
    );

    always_ff @(posedge clk_TMDS or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else if (emit) begin
            data_q <= dec_data;
            ctrl_q <= dec_ctrl;
            de_q   <= dec_de;
        end
    end

    assign data = data_q;
    assign ctrl = ctrl_q;
    assign de   = de_q;
`else
    assign data = 8'h00;
    assign ctrl = 2'b00;
    assign de   = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_deserializer.sv
// tb/tb_tmds_deserializer.sv - directed self-checking bench for tmds_deserializer
module tb_tmds_deserializer;

    localparam logic [9:0] T00 = 10'h354;
    localparam logic [9:0] T11 = 10'h2AB;
    localparam logic [9:0] D100 = 10'h100;
    localparam logic [9:0] D155 = 10'h155;

    logic       clk_TMDS = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       realign = 1'b0;
    logic [9:0] word;
    logic       word_valid;
    logic       locked;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;

    int n_tests = 0;
    int n_fail  = 0;

    // observations captured by send_bit
    logic       v_at0, l_at0, de_at0, lk_end, lk_seen;
    logic [9:0] w_at0, w_end;
    logic [7:0] d_at0;
    logic [1:0] c_at0;
    int         v_other;

    always #5 clk_TMDS = ~clk_TMDS;

    tmds_deserializer #(.LOCK_TOKENS(4), .TIMEOUT_WORDS(16)) dut (
        .clk_TMDS   (clk_TMDS),
        .rst        (rst),
        .serial_in  (serial_in),
        .realign    (realign),
        .word       (word),
        .word_valid (word_valid),
        .locked     (locked),
        .data       (data),
        .ctrl       (ctrl),
        .de         (de)
    );

    task automatic send_bit(input logic b, input logic ra, input int idx);
        @(negedge clk_TMDS);
        serial_in = b;
        realign   = ra;
        @(posedge clk_TMDS);
        #1;
        if (idx == 0) begin
            v_at0 = word_valid; w_at0 = word; l_at0 = locked;
            d_at0 = data; c_at0 = ctrl; de_at0 = de;
        end else if (word_valid) begin
            v_other++;
        end
        if (locked) lk_seen = 1'b1;
        lk_end = locked;
        w_end  = word;
    endtask

    task automatic send_word(input logic [9:0] w, input logic ra);
        for (int i = 0; i < 10; i++) send_bit(w[i], (i == 0) ? ra : 1'b0, i);
    endtask

    task automatic do_reset();
        @(negedge clk_TMDS);
        rst = 1'b1; serial_in = 1'b0; realign = 1'b0;
        @(negedge clk_TMDS);
        @(negedge clk_TMDS);
        rst = 1'b0;
        lk_seen = 1'b0;
        v_other = 0;
    endtask

    task automatic lock4();
        for (int i = 0; i < 4; i++) send_word(T00, 1'b0);
    endtask

    task automatic test_reset();
        logic [9:0] wexp;
        #1;
        n_tests++;
        if ({word, word_valid, locked, data, ctrl, de} !== 23'd0) begin
            n_fail++; $display("FAIL reset_initial: got %h, want 0", {word, word_valid, locked, data, ctrl, de});
        end
        do_reset();
        lock4();
        send_word(T00, 1'b0);
        send_word(D155, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(T00[i], 1'b0, i);
        wexp = D155;
        n_tests++;
        if (word !== wexp || locked !== 1'b1) begin
            n_fail++; $display("FAIL reset_prestate: word=%h locked=%b, want %h/1", word, locked, wexp);
        end
        @(negedge clk_TMDS);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({word, word_valid, locked, data, ctrl, de} !== 23'd0) begin
            n_fail++; $display("FAIL reset_midword: got %h, want 0", {word, word_valid, locked, data, ctrl, de});
        end
        @(negedge clk_TMDS);
        rst = 1'b0;
        lk_seen = 1'b0;
        for (int i = 0; i < 3; i++) send_word(T00, 1'b0);
        send_word(D155, 1'b0);
        n_tests++;
        if (lk_seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_relock: locked seen=%b after 3 tokens, want 0", lk_seen);
        end
    endtask

    task automatic test_lock_skew();
        do_reset();
        send_bit(1'b1, 1'b0, 5);
        send_bit(1'b1, 1'b0, 5);
        send_bit(1'b0, 1'b0, 5);
        lock4();
        n_tests++;
        if (lk_end !== 1'b0) begin
            n_fail++; $display("FAIL lock_early: locked=%b after 4th token bits, want 0", lk_end);
        end
        send_word(T00, 1'b0);
        n_tests++;
        if (l_at0 !== 1'b1 || v_at0 !== 1'b0) begin
            n_fail++; $display("FAIL lock_rise: locked=%b valid=%b, want 1/0", l_at0, v_at0);
        end
        send_word(T00, 1'b0);
        n_tests++;
        if (v_at0 !== 1'b1 || w_at0 !== T00) begin
            n_fail++; $display("FAIL lock_first_word: valid=%b word=%h, want 1/%h", v_at0, w_at0, T00);
        end
    endtask

    task automatic test_data_after_lock();
        logic [7:0] dexp;
        logic       deexp;
`ifdef TMDS_DECODE_EN
        deexp = 1'b1;
`else
        deexp = 1'b0;
`endif
        send_word(D100, 1'b0);
        n_tests++;
        if (v_at0 !== 1'b1 || w_at0 !== T00 || w_end !== T00) begin
            n_fail++; $display("FAIL data_token6: valid=%b word=%h hold=%h, want 1/%h/%h", v_at0, w_at0, w_end, T00, T00);
        end
        send_word(T11, 1'b0);
        dexp = 8'h00;
        n_tests++;
        if (v_at0 !== 1'b1 || w_at0 !== D100 || d_at0 !== dexp || de_at0 !== deexp || c_at0 !== 2'b00) begin
            n_fail++; $display("FAIL data_100: valid=%b word=%h data=%h de=%b ctrl=%b, want 1/%h/%h/%b/00",
                               v_at0, w_at0, d_at0, de_at0, c_at0, D100, dexp, deexp);
        end
    endtask

    task automatic test_ctrl_decode();
        logic [7:0] dexp;
        logic [1:0] cexp;
        logic       deexp;
        send_word(D155, 1'b0);
`ifdef TMDS_DECODE_EN
        cexp = 2'b11;
`else
        cexp = 2'b00;
`endif
        n_tests++;
        if (v_at0 !== 1'b1 || w_at0 !== T11 || d_at0 !== 8'h00 || de_at0 !== 1'b0 || c_at0 !== cexp) begin
            n_fail++; $display("FAIL ctrl_2ab: valid=%b word=%h data=%h de=%b ctrl=%b, want 1/%h/00/0/%b",
                               v_at0, w_at0, d_at0, de_at0, c_at0, T11, cexp);
        end
        send_word(T00, 1'b0);
`ifdef TMDS_DECODE_EN
        dexp = 8'hFF; deexp = 1'b1;
`else
        dexp = 8'h00; deexp = 1'b0;
`endif
        n_tests++;
        if (w_at0 !== D155 || d_at0 !== dexp || de_at0 !== deexp || c_at0 !== 2'b00) begin
            n_fail++; $display("FAIL data_155: word=%h data=%h de=%b ctrl=%b, want %h/%h/%b/00",
                               w_at0, d_at0, de_at0, c_at0, D155, dexp, deexp);
        end
        n_tests++;
        if (v_other !== 0) begin
            n_fail++; $display("FAIL stray_valid: %0d off-boundary strobes, want 0", v_other);
        end
    endtask

    task automatic test_false_token();
        do_reset();
        send_word(T00, 1'b0);
        send_word(D155, 1'b0);
        for (int i = 0; i < 3; i++) send_word(T00, 1'b0);
        send_word(D155, 1'b0);
        n_tests++;
        if (lk_seen !== 1'b0) begin
            n_fail++; $display("FAIL false_token: locked seen=%b, want 0", lk_seen);
        end
        lock4();
        send_word(D155, 1'b0);
        n_tests++;
        if (l_at0 !== 1'b1) begin
            n_fail++; $display("FAIL false_token_relock: locked=%b, want 1", l_at0);
        end
    endtask

    task automatic test_timeout();
        int nv;
        do_reset();
        lock4();
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            send_word(D155, 1'b0);
            if (v_at0) nv++;
        end
        n_tests++;
        if (lk_end !== 1'b1 || nv !== 15) begin
            n_fail++; $display("FAIL timeout_pre: locked=%b valids=%0d, want 1/15", lk_end, nv);
        end
        send_word(D155, 1'b0);
        n_tests++;
        if (l_at0 !== 1'b0 || v_at0 !== 1'b0 || v_other !== 0) begin
            n_fail++; $display("FAIL timeout_drop: locked=%b valid=%b stray=%0d, want 0/0/0", l_at0, v_at0, v_other);
        end
    endtask

    task automatic test_realign();
        do_reset();
        lock4();
        send_word(T00, 1'b0);
        send_word(D155, 1'b0);
        n_tests++;
        if (l_at0 !== 1'b1 || v_at0 !== 1'b1) begin
            n_fail++; $display("FAIL realign_pre: locked=%b valid=%b, want 1/1", l_at0, v_at0);
        end
        send_word(T00, 1'b1);
        n_tests++;
        if (l_at0 !== 1'b0 || v_at0 !== 1'b0) begin
            n_fail++; $display("FAIL realign_drop: locked=%b valid=%b, want 0/0", l_at0, v_at0);
        end
        for (int i = 0; i < 3; i++) send_word(T00, 1'b0);
        n_tests++;
        if (lk_end !== 1'b0) begin
            n_fail++; $display("FAIL realign_early: locked=%b, want 0", lk_end);
        end
        send_word(D155, 1'b0);
        n_tests++;
        if (l_at0 !== 1'b1) begin
            n_fail++; $display("FAIL realign_relock: locked=%b, want 1", l_at0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lk_seen = 1'b0;
        v_other = 0;
        test_reset();
        test_lock_skew();
        test_data_after_lock();
        test_ctrl_decode();
        test_false_token();
        test_timeout();
        test_realign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
